avalon_msg_generator: RTL
=========================

Name: avalon_msg_generator

Overview:
- Transmit-side counterpart of the Avalon-ST enforcement path: builds well-formed Avalon-ST messages from a simple command (length, fill pattern) and drives them as master on an avalon_st_if.
- Used as the traffic source in front of the enforcer and as a standalone message transmitter.
- Honours ready backpressure.
- Can optionally inject framing errors (missing/double sop) to exercise downstream protocol checkers.

Parameters:
- DATA_WIDTH_IN_BYTES, 8: bytes per beat (W); data width = 8*W. Must be ≥1.
- LEN_WIDTH, 16: width of the message length field, in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset; 0 = reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  generator idle and able to accept a command
- cmd_length  in  LEN_WIDTH  message length in bytes
- cmd_pattern  in  8  value of the first payload byte
- msg  avalon_st_if.master  -  data[8W], valid, ready (in), sop, eop, empty[$clog2(W) bits, min 1]
- busy  out  1  high while a message is in flight
- msg_done  out  1  one-cycle pulse after the last beat handshake

Behaviour:
- Reset (rst=0, async): cmd_ready=0, busy=0, msg_done=0, msg.valid=0, msg.sop=0, msg.eop=0, msg.data=0, msg.empty=0, state=IDLE. All outputs are registered. The first clock after reset release sets cmd_ready=1.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - cmd_ready=1.
  - Command is accepted on cmd_valid&cmd_ready. The block latches length and pattern, sets beats = ceil(length/W) and last_empty = beats*W - length, then moves to SEND.
  - First beat: valid=1 and sop=1 on the cycle after acceptance (latency 1).
  - A length of 0 is accepted, emits no beats and goes straight to DONE.
- SEND:
  - Beat k (0-based) carries bytes k*W .. k*W+W-1. Byte i of the message = (cmd_pattern + i) mod 256.
  - Byte 0 of each beat is in data[8W-1 -: 8] (big-endian).
  - sop=1 only on beat 0. eop=1 only on beat beats-1.
  - empty = last_empty on the eop beat, else 0. Unused trailing bytes on the eop beat are driven 0.
  - A single-beat message has sop=eop=1 on the same beat.
  - Handshake: a beat transfers on valid&ready. While valid=1 and ready=0, data, sop, eop and empty are held stable.
  - valid stays high between beats: no bubbles while ready=1, so throughput is 1 beat/cycle.
  - On the eop-beat handshake: valid drops the next cycle, unless in the same cycle it is replaced by … nothing. There is no overlap with the next message. Transition to DONE.
- DONE:
  - msg_done=1 for exactly one cycle, cmd_ready=1 on that same cycle, then return to IDLE.
  - A command presented during DONE is accepted there (treated as IDLE). Minimum gap between messages is one idle cycle.
- busy = (state == SEND).
- cmd_* is ignored while cmd_ready=0.
- Beat counter and byte offset are LEN_WIDTH+1 bits wide, so no wrap for the maximum length (2^LEN_WIDTH-1).
- Byte pattern wraps modulo 256 freely.
- Reset mid-message: outputs clear immediately, with no eop emitted. The downstream enforcer is responsible for the truncated packet.

Optional Feature:
- Macro: AVALON_MSG_GEN_ERR_INJECT_EN.
- With the macro: two extra input ports, cmd_inject_missing_sop and cmd_inject_double_sop, latched with the command.
  - missing_sop: beat 0 is sent with sop=0.
  - double_sop: beat 1 also carries sop=1; ignored if beats < 2.
  - Both set: missing_sop wins.
  - Payload, eop, empty and timing are unchanged.
- Without the macro: the ports do not exist and framing is always legal.

Decomposition:
- Package avalon_msg_gen_pkg holds:
  - typedef enum gen_state_t {IDLE, SEND, DONE};
  - the function computing the beat count / last_empty from length and W;
  - the function building a beat from start byte and pattern.
- Sub-module avalon_beat_builder (combinational): takes byte offset, pattern and valid-byte count; produces data[8W] with zero-fill.

Test Plan (W=8):
- Length 20, pattern 0x22, ready=1 → 3 beats on consecutive cycles.
  - beat0: sop=1, data = 22 23 … 29.
  - beat2: eop=1, empty=4, data = 32 33 34 35 00 00 00 00.
  - msg_done pulses 1 cycle after beat2.
- Length 8 → single beat with sop=eop=1, empty=0. Length 0 → no valid, msg_done pulse, cmd_ready back in 2 cycles.
- Length 24 with ready toggling every cycle → each beat held while ready=0, exactly 3 transfers, data never changes while stalled.
- Back-to-back: cmd_valid held high with lengths 9 then 16 → second sop appears exactly 2 cycles after the first message's eop handshake; no beat is dropped or duplicated.
- Reset asserted mid-message (after beat 1 of 4) → valid=sop=eop=0 immediately; first cycle after release cmd_ready=1, and a new command starts cleanly with sop.
- With AVALON_MSG_GEN_ERR_INJECT_EN:
  - missing_sop, length 16 → no sop, eop on beat 1.
  - double_sop, length 24 → sop on beats 0 and 1.
  - Fed into the enforcer, these raise missing_sop_error and double_sop_error respectively.

Source files
------------

// File: rtl/avalon_msg_gen_pkg.sv
// Shared types and helpers for the Avalon-ST message generator: FSM states,
// beat/empty arithmetic and the per-lane payload byte function.
package avalon_msg_gen_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} gen_state_t;

  function automatic int unsigned calc_beats(input int unsigned len, input int unsigned w);
    return (len + w - 1) / w;
  endfunction

  function automatic int unsigned calc_last_empty(input int unsigned len, input int unsigned w);
    return calc_beats(len, w) * w - len;
  endfunction

  // Payload byte i of a message is pattern + i, wrapping modulo 256.
  function automatic logic [7:0] beat_byte(input int unsigned start_byte,
                                           input logic [7:0]  pattern,
                                           input int unsigned lane);
    return 8'(start_byte + 32'(pattern) + lane);
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming interface: data, valid/ready handshake, sop/eop framing
// and an empty count of unused trailing bytes on the eop beat.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 8
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             ready;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/avalon_beat_builder.sv
// Combinational beat builder: lays out nvalid payload bytes big-endian starting
// at a message byte offset, zero-filling the unused trailing lanes.
module avalon_beat_builder
  import avalon_msg_gen_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int LEN_WIDTH           = 16,
  parameter int BCNT_W              = $clog2(DATA_WIDTH_IN_BYTES + 1)
) (
  input  logic [LEN_WIDTH:0]               offset,
  input  logic [7:0]                       pattern,
  input  logic [BCNT_W-1:0]                nvalid,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0] data
);
  localparam int unsigned W = DATA_WIDTH_IN_BYTES;

  always_comb begin
    data = '0;
    for (int unsigned j = 0; j < W; j++) begin
      if (j < 32'(nvalid)) data[8*(W-1-j) +: 8] = beat_byte(32'(offset), pattern, j);
    end
  end

endmodule

// File: rtl/avalon_msg_generator.sv
// Avalon-ST message generator: turns a (length, pattern) command into a framed
// stream honouring ready. Optional framing-error injection: AVALON_MSG_GEN_ERR_INJECT_EN.
module avalon_msg_generator
  import avalon_msg_gen_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_length,
  input  logic [7:0]           cmd_pattern,
`ifdef AVALON_MSG_GEN_ERR_INJECT_EN
  input  logic                 cmd_inject_missing_sop,
  input  logic                 cmd_inject_double_sop,
`endif
  avalon_st_if.master          msg,
  output logic                 busy,
  output logic                 msg_done
);
  localparam int unsigned W       = DATA_WIDTH_IN_BYTES;
  localparam int          CNT_W   = LEN_WIDTH + 1;
  localparam int          EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int          BCNT_W  = $clog2(DATA_WIDTH_IN_BYTES + 1);

  gen_state_t         state_p0, state_d;
  logic               cmd_ready_p0, cmd_ready_d;
  logic               busy_p0, busy_d;
  logic               done_p0, done_d;
  logic               vld_p0, vld_d;
  logic               sop_p0, sop_d;
  logic               eop_p0, eop_d;
  logic [EMPTY_W-1:0] empty_p0, empty_d;
  logic [8*W-1:0]     data_p0, data_d;
  logic [CNT_W-1:0]   beat_idx_p0, beat_idx_d;
  logic [CNT_W-1:0]   beats_p0, beats_d;
  logic [CNT_W-1:0]   off_p0, off_d;
  logic [7:0]         pat_p0, pat_d;
  logic [EMPTY_W-1:0] last_empty_p0, last_empty_d;

  logic               accept, handshake, nxt_last, first_sop, dbl_sop_p0;
  logic [CNT_W-1:0]   cmd_beats, nxt_idx, b_off;
  logic [EMPTY_W-1:0] cmd_last_empty;
  logic [7:0]         b_pat;
  logic [BCNT_W-1:0]  b_nvalid;
  logic [8*W-1:0]     b_data;

  assign accept         = cmd_valid && cmd_ready_p0 && (state_p0 != SEND);
  assign handshake      = vld_p0 && msg.ready;
  assign cmd_beats      = CNT_W'(calc_beats(32'(cmd_length), W));
  assign cmd_last_empty = EMPTY_W'(calc_last_empty(32'(cmd_length), W));
  assign nxt_idx        = beat_idx_p0 + 1'b1;
  assign nxt_last       = (nxt_idx == beats_p0 - 1'b1);

`ifdef AVALON_MSG_GEN_ERR_INJECT_EN
  assign first_sop = !cmd_inject_missing_sop;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dbl_sop_p0 <= 1'b0;
    else if (accept) dbl_sop_p0 <= cmd_inject_double_sop && !cmd_inject_missing_sop;
  end
`else
  assign first_sop  = 1'b1;
  assign dbl_sop_p0 = 1'b0;
`endif

  // One builder serves both the first beat (from the command) and each following beat.
  always_comb begin
    if (state_p0 == SEND) begin
      b_off    = off_p0 + CNT_W'(W);
      b_pat    = pat_p0;
      b_nvalid = nxt_last ? BCNT_W'(W) - BCNT_W'(last_empty_p0) : BCNT_W'(W);
    end else begin
      b_off    = '0;
      b_pat    = cmd_pattern;
      b_nvalid = (cmd_beats == CNT_W'(1)) ? BCNT_W'(W) - BCNT_W'(cmd_last_empty) : BCNT_W'(W);
    end
  end

  avalon_beat_builder #(
    .DATA_WIDTH_IN_BYTES (DATA_WIDTH_IN_BYTES),
    .LEN_WIDTH           (LEN_WIDTH),
    .BCNT_W              (BCNT_W)
  ) u_builder (
    .offset  (b_off),
    .pattern (b_pat),
    .nvalid  (b_nvalid),
    .data    (b_data)
  );

  always_comb begin
    state_d      = state_p0;
    cmd_ready_d  = cmd_ready_p0;
    busy_d       = busy_p0;
    done_d       = 1'b0;
    vld_d        = vld_p0;
    sop_d        = sop_p0;
    eop_d        = eop_p0;
    empty_d      = empty_p0;
    data_d       = data_p0;
    beat_idx_d   = beat_idx_p0;
    beats_d      = beats_p0;
    off_d        = off_p0;
    pat_d        = pat_p0;
    last_empty_d = last_empty_p0;
    case (state_p0)
      IDLE, DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (accept) begin
          pat_d        = cmd_pattern;
          beats_d      = cmd_beats;
          last_empty_d = cmd_last_empty;
          off_d        = '0;
          beat_idx_d   = '0;
          if (cmd_length == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = SEND;
            cmd_ready_d = 1'b0;
            busy_d      = 1'b1;
            vld_d       = 1'b1;
            sop_d       = first_sop;
            eop_d       = (cmd_beats == CNT_W'(1));
            empty_d     = (cmd_beats == CNT_W'(1)) ? cmd_last_empty : '0;
            data_d      = b_data;
          end
        end
      end
      SEND: begin
        if (handshake) begin
          if (eop_p0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            vld_d       = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            empty_d     = '0;
            data_d      = '0;
          end else begin
            beat_idx_d = nxt_idx;
            off_d      = b_off;
            data_d     = b_data;
            sop_d      = dbl_sop_p0 && (beat_idx_p0 == '0);
            eop_d      = nxt_last;
            empty_d    = nxt_last ? last_empty_p0 : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: every output and all message context are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0      <= IDLE;
      cmd_ready_p0  <= 1'b0;
      busy_p0       <= 1'b0;
      done_p0       <= 1'b0;
      vld_p0        <= 1'b0;
      sop_p0        <= 1'b0;
      eop_p0        <= 1'b0;
      empty_p0      <= '0;
      data_p0       <= '0;
      beat_idx_p0   <= '0;
      beats_p0      <= '0;
      off_p0        <= '0;
      pat_p0        <= '0;
      last_empty_p0 <= '0;
    end else begin
      state_p0      <= state_d;
      cmd_ready_p0  <= cmd_ready_d;
      busy_p0       <= busy_d;
      done_p0       <= done_d;
      vld_p0        <= vld_d;
      sop_p0        <= sop_d;
      eop_p0        <= eop_d;
      empty_p0      <= empty_d;
      data_p0       <= data_d;
      beat_idx_p0   <= beat_idx_d;
      beats_p0      <= beats_d;
      off_p0        <= off_d;
      pat_p0        <= pat_d;
      last_empty_p0 <= last_empty_d;
    end
  end

  assign cmd_ready = cmd_ready_p0;
  assign busy      = busy_p0;
  assign msg_done  = done_p0;
  assign msg.valid = vld_p0;
  assign msg.sop   = sop_p0;
  assign msg.eop   = eop_p0;
  assign msg.empty = empty_p0;
  assign msg.data  = data_p0;

endmodule
